// File: rtl/m2m_pkg.sv
// Shared types and default widths for the memory-to-memory datapath blocks.
package m2m_pkg;

   localparam int unsigned M2M_ADDR_W  = 8;
   localparam int unsigned M2M_DATA_W  = 8;
   localparam int unsigned FETCH_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      CAP_B,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/operand_fetch8_if.sv
// Request, memory and operand signals of the operand-fetch sequencer.
interface operand_fetch8_if
   import m2m_pkg::*;
#(
   parameter int unsigned ADDR_W = M2M_ADDR_W,
   parameter int unsigned DATA_W = M2M_DATA_W
);

   logic              start;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic              load_en;
   logic              busy;

   modport slave (
      input  start, addr_a, addr_b, mem_rdata,
      output mem_addr, mem_rd, operand_a, operand_b, load_en, busy
   );

   modport master (
      output start, addr_a, addr_b, mem_rdata,
      input  mem_addr, mem_rd, operand_a, operand_b, load_en, busy
   );

endinterface

// File: rtl/operand_fetch8.sv
// Fetches two operands from synchronous-read memory and strobes them downstream.
// OPERAND_FETCH_STAT_EN adds a 16-bit completed-fetch counter on fetch_count.
module operand_fetch8
   import m2m_pkg::*;
#(
   parameter int unsigned ADDR_W = M2M_ADDR_W,
   parameter int unsigned DATA_W = M2M_DATA_W
) (
   input  logic                   CLK,
   input  logic                   reset_n,
   operand_fetch8_if.slave        bus
`ifdef OPERAND_FETCH_STAT_EN
   ,
   output logic [FETCH_CNT_W-1:0] fetch_count
`endif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic              mem_rd_q, mem_rd_d;
   logic              load_en_q, load_en_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;

   // mem_addr_q doubles as the latched A address; B waits in addr_b_q.
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      addr_b_d   = addr_b_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = RD_A;
               mem_addr_d = bus.addr_a;
               addr_b_d   = bus.addr_b;
            end
         end
         RD_A: begin
            state_d    = RD_B;
            mem_addr_d = addr_b_q;
         end
         RD_B: begin
            state_d = CAP_B;
            op_a_d  = bus.mem_rdata;
         end
         CAP_B: begin
            state_d = DONE;
            op_b_d  = bus.mem_rdata;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      mem_rd_d  = (state_d == RD_A) || (state_d == RD_B);
      load_en_d = (state_d == DONE);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         addr_b_q   <= '0;
         mem_rd_q   <= 1'b0;
         load_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         addr_b_q   <= addr_b_d;
         mem_rd_q   <= mem_rd_d;
         load_en_q  <= load_en_d;
         busy_q     <= busy_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.load_en   = load_en_q;
   assign bus.busy      = busy_q;
   assign bus.operand_a = op_a_q;
   assign bus.operand_b = op_b_q;

`ifdef OPERAND_FETCH_STAT_EN
   logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;

   // Counts on leaving DONE; wraps naturally at full scale.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == DONE) begin
         cnt_d = cnt_q + FETCH_CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fetch_count = cnt_q;
`endif

endmodule

// File: doc/operand_fetch8.md
# operand_fetch8

Memory operand-fetch sequencer for the memory-to-memory datapath. On a start request it reads two 8-bit operands from synchronous-read data memory, one after the other. It then presents them on registered outputs with a one-cycle load strobe. The strobe and data drive the `inputValue` ports of the downstream `register8` operand registers; this block sits directly upstream of them.

## Interface
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: operand and memory data width.
- `CLK`  in  1  single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  fetch request; sampled only when `busy`=0.
- `addr_a`  in  ADDR_W  address of operand A; latched when start is accepted.
- `addr_b`  in  ADDR_W  address of operand B; latched when start is accepted.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rd`  out  1  memory read enable.
- `mem_rdata`  in  DATA_W  memory read data; valid the cycle after `mem_rd`.
- `operand_a`  out  DATA_W  fetched operand A, registered.
- `operand_b`  out  DATA_W  fetched operand B, registered.
- `load_en`  out  1  one-cycle strobe: operands valid, load downstream registers.
- `busy`  out  1  high whenever the state is not IDLE.
- `fetch_count`  out  16  number of completed fetches; present only with `OPERAND_FETCH_STAT_EN`.

## Operation
- FSM states: IDLE → RD_A → RD_B → CAP_B → DONE → IDLE.
- IDLE
  - `start`=1 latches `addr_a` and `addr_b` and moves to RD_A.
  - `start`=0 stays in IDLE.
- RD_A: `mem_addr`=latched A, `mem_rd`=1; unconditionally moves to RD_B.
- RD_B: `mem_addr`=latched B, `mem_rd`=1. `mem_rdata` now holds A, captured into `operand_a` at the exit edge.
- CAP_B: `mem_rd`=0, `mem_addr` holds B. `mem_rdata` holds B, captured into `operand_b` at the exit edge.
- DONE: `load_en`=1 for exactly this cycle; `operand_a` and `operand_b` are valid. Returns to IDLE.
- Outside their capture edges, `operand_a` and `operand_b` hold their last value. They remain valid after DONE until the next fetch overwrites them.
- `start` while `busy`=1 (including in DONE) is ignored; it is not queued.
- `addr_a`==`addr_b` is legal: the location is read twice and both operands get the same value.
- Changes on `addr_a`/`addr_b` after acceptance have no effect on the fetch in progress.

## Timing
- Reset (`reset_n`=0, asynchronous): state=IDLE; `mem_addr`=0, `mem_rd`=0, `operand_a`=0, `operand_b`=0, `load_en`=0, `busy`=0, `fetch_count`=0.
- Reset mid-fetch aborts immediately. No `load_en` is issued, and operands read 0 after release.
- `start` sampled at edge 0. RD_A is cycle 1, RD_B cycle 2, CAP_B cycle 3, DONE cycle 4 (`load_en`=1), IDLE cycle 5.
- Fixed latency of 4 cycles from accepted start to `load_en`. The earliest next start is accepted at the edge ending cycle 5, giving a throughput of 1 fetch per 5 cycles.
- `busy` rises in cycle 1 and falls in cycle 5.
- All outputs are registered or decoded from the state register only; there is no combinational path from `start` or `mem_rdata` to any output.

## Configuration
- `OPERAND_FETCH_STAT_EN` defined
  - Adds the `fetch_count` port and a 16-bit counter.
  - The counter increments on each DONE cycle, wraps 0xFFFF→0x0000, and resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `m2m_pkg`:
  - state encoding enum `fetch_state_t` (IDLE, RD_A, RD_B, CAP_B, DONE);
  - default width constants `M2M_ADDR_W`=8 and `M2M_DATA_W`=8.
- No sub-module: FSM, address latch, operand registers and optional counter live in one module.

## Test plan
- Reset: hold `reset_n`=0 two cycles → all outputs 0 and `busy`=0. Release → still IDLE, `mem_rd`=0.
- Basic fetch: mem[0x10]=0x3C, mem[0x20]=0xA5, start with A=0x10, B=0x20 →
  - `mem_addr` reads 0x10, then 0x20;
  - `load_en`=1 in cycle 4 with `operand_a`=0x3C, `operand_b`=0xA5;
  - `busy` high cycles 1–4.
- Ignored start: pulse `start` with A=0x01 during cycles 2 and 4 of a fetch → no extra fetch; operands reflect only the first request.
- Same address: A=B=0x7F, mem[0x7F]=0xFF → both operands 0xFF.
- Reset mid-fetch: assert `reset_n`=0 in cycle 2 → `load_en` never pulses; operands 0. A new start after release completes normally.
- Stat (with `OPERAND_FETCH_STAT_EN`):
  - 128 back-to-back fetches of mem[i], mem[i+1] (mirroring the `register8` count-up sweep) → `fetch_count`=128, and each `load_en` shows the expected pair;
  - preload the counter to 0xFFFF via a force, then one fetch → 0x0000.
